comet_ii_mem_arbiter: RTL and testbench

- Shares one single-port program/data memory between the COMET II core and a host port used for program load and debug peek/poke.
- Arbitrates every cycle with round-robin, host lock and starvation limit; returns cpu_hold to stall the core while it is denied.
- Splits a core cycle that asserts read and write together into a write cycle followed by a read cycle.
- Memory is asynchronous-read and written at the mclk rising edge; the core's memory port connects directly.

---
 rtl/comet_ii_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_comet_ii_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/comet_ii_mem_arbiter.sv
// Arbiter sharing one single-port memory between the COMET II core and a host
// load/debug port. Round-robin with host lock and starvation limit. A core
// cycle that reads and writes together is split into a write then a read.
module comet_ii_mem_arbiter #(
  parameter int unsigned AW             = 16,
  parameter int unsigned DW             = 16,
  parameter int unsigned HOST_MAX_BURST = 8
) (
  input  logic          mclk,
  input  logic          rst_n,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_raddr,
  output logic [DW-1:0] cpu_rdata,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_hold,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  localparam int unsigned    BW          = 8;
  localparam logic [BW-1:0] BURST_LIMIT = BW'(HOST_MAX_BURST);
  localparam logic [BW-1:0] BURST_SAT   = '1;

  logic [0:0]    r_st;
  logic          r_last_host;
  logic [BW-1:0] r_burst_cnt;
  logic [DW-1:0] r_host_rdata;
  logic          r_host_rvalid;

  logic [0:0]    w_st_nxt;
  logic          w_last_host_nxt;
  logic [BW-1:0] w_burst_nxt;
  logic [DW-1:0] w_host_rdata_nxt;
  logic          w_host_rvalid_nxt;

  logic          w_cpu_act;
  logic          w_host_win;

  assign w_cpu_act = cpu_re | cpu_we;

  // Host wins when the core is quiet, while locked within its burst budget,
  // or on its round-robin turn when unlocked.
  assign w_host_win = host_req &
                      (~w_cpu_act |
                       (host_lock & (r_burst_cnt < BURST_LIMIT)) |
                       (~host_lock & ~r_last_host));

  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;

  // Next-state and memory-port steering; reset forces the port quiet.
  always_comb begin
    w_st_nxt          = r_st;
    w_last_host_nxt   = r_last_host;
    w_burst_nxt       = r_burst_cnt;
    w_host_rdata_nxt  = r_host_rdata;
    w_host_rvalid_nxt = 1'b0;
    mem_en            = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = cpu_raddr;
    mem_wdata         = cpu_wdata;
    host_gnt          = 1'b0;
    cpu_hold          = 1'b0;

    if (r_st == ST_SPLIT) begin
      // Second half of a split: the core read, host blocked.
      mem_en          = 1'b1;
      w_st_nxt        = ST_ARB;
      w_last_host_nxt = 1'b0;
      w_burst_nxt     = '0;
    end else if (w_host_win) begin
      mem_en          = 1'b1;
      mem_we          = host_we;
      mem_addr        = host_addr;
      mem_wdata       = host_wdata;
      host_gnt        = 1'b1;
      cpu_hold        = w_cpu_act;
      w_last_host_nxt = 1'b1;
      if (w_cpu_act) begin
        w_burst_nxt = (r_burst_cnt == BURST_SAT) ? r_burst_cnt
                                                  : r_burst_cnt + BW'(1);
      end else begin
        w_burst_nxt = '0;
      end
      if (!host_we) begin
        w_host_rdata_nxt  = mem_rdata;
        w_host_rvalid_nxt = 1'b1;
      end
    end else if (w_cpu_act) begin
      mem_en          = 1'b1;
      mem_we          = cpu_we;
      mem_addr        = cpu_we ? cpu_waddr : cpu_raddr;
      w_last_host_nxt = 1'b0;
      w_burst_nxt     = '0;
      if (cpu_re && cpu_we) begin
        cpu_hold = 1'b1;
        w_st_nxt = ST_SPLIT;
      end
    end

    if (!rst_n) begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      host_gnt = 1'b0;
      cpu_hold = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      r_st          <= ST_ARB;
      r_last_host   <= 1'b0;
      r_burst_cnt   <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_st          <= w_st_nxt;
      r_last_host   <= w_last_host_nxt;
      r_burst_cnt   <= w_burst_nxt;
      r_host_rdata  <= w_host_rdata_nxt;
      r_host_rvalid <= w_host_rvalid_nxt;
    end
  end

endmodule

// File: tb/tb_comet_ii_mem_arbiter.sv
// Table-driven bench for comet_ii_mem_arbiter: one record per cycle, applied
// on the falling edge and checked 1 time unit later against a memory model.
module tb_comet_ii_mem_arbiter;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_raddr = '0, cpu_waddr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_hold;
  logic        host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [15:0] host_addr = '0, host_wdata = '0;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] bmem [0:65535] = '{default: 16'h0000};

  int n_checks = 0;
  int n_err    = 0;

  always #5 mclk = ~mclk;

  // Asynchronous-read, edge-written memory model.
  assign mem_rdata = bmem[mem_addr];
  always @(posedge mclk) if (mem_en && mem_we) bmem[mem_addr] <= mem_wdata;

  comet_ii_mem_arbiter #(.AW(16), .DW(16), .HOST_MAX_BURST(8)) dut (
    .mclk(mclk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_hold(cpu_hold),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rst_n, cre, cwe;
    logic [15:0] craddr, cwaddr, cwdata;
    logic        hreq, hwe, hlock;
    logic [15:0] haddr, hwdata;
  } vin_t;

  typedef struct {
    string       name;
    vin_t        in;
    logic [4:0]  f;      // {mem_en, mem_we, host_gnt, cpu_hold, host_rvalid}
    logic [15:0] addr;   // checked when mem_en expected
    logic [15:0] rd;     // host_rdata
    logic        chkc;   // check cpu_rdata
    logic [15:0] crd;
  } vec_t;

  vin_t ci;
  vec_t vq[$];

  task automatic cpu(input logic re, input logic we, input logic [15:0] ra,
                     input logic [15:0] wa, input logic [15:0] wd);
    ci.cre = re; ci.cwe = we; ci.craddr = ra; ci.cwaddr = wa; ci.cwdata = wd;
  endtask

  task automatic host(input logic req, input logic we, input logic lock,
                      input logic [15:0] a, input logic [15:0] wd);
    ci.hreq = req; ci.hwe = we; ci.hlock = lock; ci.haddr = a; ci.hwdata = wd;
  endtask

  task automatic v(input string nm, input logic [4:0] f, input logic [15:0] addr,
                   input logic [15:0] rd, input logic chkc, input logic [15:0] crd);
    vec_t t;
    t.name = nm; t.in = ci; t.f = f; t.addr = addr; t.rd = rd;
    t.chkc = chkc; t.crd = crd;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h, required %h", nm, fld, act, exp);
    end
  endtask

  initial begin
    ci = '{default: '0};

    // Reset with a core read pending, then release.
    ci.rst_n = 1'b0;
    cpu(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);
    v("rst0", 5'b00010, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    v("rst1", 5'b00010, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    ci.rst_n = 1'b1;
    v("rst_rel", 5'b10000, 16'h0010, 16'h0000, 1'b1, 16'h0000);

    // Host program load with the core idle, then read-back.
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      host(1'b1, 1'b1, 1'b0, 16'(k), 16'h1234 + 16'(k));
      v($sformatf("hload%0d", k), 5'b11100, 16'(k), 16'h0000, 1'b0, 16'h0000);
    end
    host(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000);
    v("hrd", 5'b10100, 16'h0002, 16'h0000, 1'b0, 16'h0000);
    host(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    v("hrd_rv", 5'b00001, 16'h0000, 16'h1236, 1'b0, 16'h0000);

    // Core read alone hands the round-robin turn back to the host.
    cpu(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000);
    v("crd3", 5'b10000, 16'h0003, 16'h1236, 1'b1, 16'h1237);

    // Unlocked contention alternates H, C, H, C, H, C.
    host(1'b1, 1'b1, 1'b0, 16'h0100, 16'h5555);
    cpu(1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) v($sformatf("ulk_h%0d", k), 5'b11110, 16'h0100, 16'h1236, 1'b0, 16'h0000);
      else            v($sformatf("ulk_c%0d", k), 5'b10000, 16'h0001, 16'h1236, 1'b1, 16'h1235);
    end

    // Locked burst: 8 host grants, one core slot, host resumes.
    host(1'b1, 1'b1, 1'b1, 16'h0200, 16'h7777);
    cpu(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000);
    for (int k = 0; k < 8; k++)
      v($sformatf("lk_h%0d", k), 5'b11110, 16'h0200, 16'h1236, 1'b0, 16'h0000);
    v("lk_c", 5'b10000, 16'h0002, 16'h1236, 1'b1, 16'h1236);
    v("lk_resume", 5'b11110, 16'h0200, 16'h1236, 1'b0, 16'h0000);
    host(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    v("idle", 5'b00000, 16'h0000, 16'h1236, 1'b0, 16'h0000);

    // Split: write then read, host held off until the read completes.
    cpu(1'b1, 1'b1, 16'h0020, 16'h0020, 16'hBEEF);
    v("sp_wr", 5'b11010, 16'h0020, 16'h1236, 1'b0, 16'h0000);
    host(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    v("sp_rd", 5'b10000, 16'h0020, 16'h1236, 1'b1, 16'hBEEF);
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    v("sp_hgnt", 5'b10100, 16'h0020, 16'h1236, 1'b0, 16'h0000);
    host(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    v("sp_hrv", 5'b00001, 16'h0000, 16'hBEEF, 1'b0, 16'h0000);

    // Reset during the split cycle abandons the read.
    cpu(1'b1, 1'b1, 16'h0030, 16'h0030, 16'h1111);
    v("rs_wr", 5'b11010, 16'h0030, 16'hBEEF, 1'b0, 16'h0000);
    ci.rst_n = 1'b0;
    v("rs_split", 5'b00010, 16'h0000, 16'hBEEF, 1'b0, 16'h0000);
    ci.rst_n = 1'b1;
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    v("rs_after", 5'b00000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    host(1'b1, 1'b1, 1'b0, 16'h0040, 16'h4242);
    cpu(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0000);
    v("rs_h", 5'b11110, 16'h0040, 16'h0000, 1'b0, 16'h0000);
    host(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    v("rs_c", 5'b10000, 16'h0030, 16'h0000, 1'b1, 16'h1111);

    // Top of the address space passes through unchanged.
    cpu(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    host(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0F0F);
    v("top_wr", 5'b11100, 16'hFFFF, 16'h0000, 1'b0, 16'h0000);
    host(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
    v("top_rd", 5'b10100, 16'hFFFF, 16'h0000, 1'b0, 16'h0000);
    host(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    v("top_rv", 5'b00001, 16'h0000, 16'h0F0F, 1'b0, 16'h0000);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge mclk);
      rst_n      = vq[i].in.rst_n;
      cpu_re     = vq[i].in.cre;
      cpu_we     = vq[i].in.cwe;
      cpu_raddr  = vq[i].in.craddr;
      cpu_waddr  = vq[i].in.cwaddr;
      cpu_wdata  = vq[i].in.cwdata;
      host_req   = vq[i].in.hreq;
      host_we    = vq[i].in.hwe;
      host_lock  = vq[i].in.hlock;
      host_addr  = vq[i].in.haddr;
      host_wdata = vq[i].in.hwdata;
      #1;
      chk(vq[i].name, "mem_en",      16'(mem_en),      16'(vq[i].f[4]));
      chk(vq[i].name, "mem_we",      16'(mem_we),      16'(vq[i].f[3]));
      chk(vq[i].name, "host_gnt",    16'(host_gnt),    16'(vq[i].f[2]));
      chk(vq[i].name, "cpu_hold",    16'(cpu_hold),    16'(vq[i].f[1]));
      chk(vq[i].name, "host_rvalid", 16'(host_rvalid), 16'(vq[i].f[0]));
      chk(vq[i].name, "host_rdata",  host_rdata,       vq[i].rd);
      if (vq[i].f[4]) chk(vq[i].name, "mem_addr", mem_addr, vq[i].addr);
      if (vq[i].chkc) chk(vq[i].name, "cpu_rdata", cpu_rdata, vq[i].crd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
